// File: rtl/ad_ip_jesd204_tpl_dac_framer_core_if.sv
// DMA-side and link-side streaming bus for the JESD204 TPL DAC framer core.
//   dac_valid / dac_ready / dac_data    : per-channel sample beats from DMA/DDS
//   link_valid / link_ready / link_data : framed lane octets to the link layer
// slave  : the framer core (consumes DAC beats, produces link beats)
// master : the surrounding logic (produces DAC beats, consumes link beats)
interface ad_ip_jesd204_tpl_dac_framer_core_if #(
    parameter int DAC_DATA_WIDTH  = 32,
    parameter int LINK_DATA_WIDTH = 32
);
    logic                       dac_valid;
    logic                       dac_ready;
    logic [DAC_DATA_WIDTH-1:0]  dac_data;
    logic                       link_valid;
    logic                       link_ready;
    logic [LINK_DATA_WIDTH-1:0] link_data;

    modport master (
        output dac_valid, dac_data, link_ready,
        input  dac_ready, link_valid, link_data
    );

    modport slave (
        input  dac_valid, dac_data, link_ready,
        output dac_ready, link_valid, link_data
    );
endinterface

// File: rtl/ad_ip_jesd204_tpl_dac_framer_core.sv
// Transmit transport-layer core for the JESD204 DAC path.
// Selects a per-channel sample source (DMA, constant, ramp, zero), gates the
// stream with the external-sync arm state machine and maps the samples into
// JESD204 lane octets for the link-layer transmitter.
// Ports:
//   clk, reset           : link clock, synchronous active-high reset
//   bus (slave)          : DMA beat handshake in, framed link beat out
//   dac_src_sel          : 2 bits per channel: 0 DMA, 1 constant, 2 ramp, 3 zero
//   dac_const            : 16-bit constant sample per channel
//   dac_ext_sync_arm     : arm request pulse
//   dac_ext_sync_disarm  : disarm request pulse
//   dac_sync_in          : external sync level
//   dac_sync_manual_req  : software sync level
//   dac_sync_status      : high while ARMED
//   dac_dunf             : one-cycle pulse on a consumed DMA underflow beat
module ad_ip_jesd204_tpl_dac_framer_core #(
    parameter int NUM_LANES         = 1,
    parameter int NUM_CHANNELS      = 1,
    parameter int SAMPLES_PER_FRAME = 1,
    parameter int OCTETS_PER_BEAT   = 4,
    parameter int EXT_SYNC          = 0,
    parameter int LINK_DATA_WIDTH   = NUM_LANES*OCTETS_PER_BEAT*8,
    parameter int DATA_PATH_WIDTH   = LINK_DATA_WIDTH/(16*NUM_CHANNELS),
    parameter int DAC_DATA_WIDTH    = DATA_PATH_WIDTH*16*NUM_CHANNELS
) (
    input  logic                        clk,
    input  logic                        reset,
    ad_ip_jesd204_tpl_dac_framer_core_if.slave bus,
    input  logic [2*NUM_CHANNELS-1:0]   dac_src_sel,
    input  logic [16*NUM_CHANNELS-1:0]  dac_const,
    input  logic                        dac_ext_sync_arm,
    input  logic                        dac_ext_sync_disarm,
    input  logic                        dac_sync_in,
    input  logic                        dac_sync_manual_req,
    output logic                        dac_sync_status,
    output logic                        dac_dunf
);
    localparam int CH_W   = 16*DATA_PATH_WIDTH;
    localparam int F      = NUM_CHANNELS*SAMPLES_PER_FRAME*2/NUM_LANES;
    localparam int BEAT_W = OCTETS_PER_BEAT*8;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        RUNNING
    } sync_state_t;

    sync_state_t state;
    sync_state_t state_next;

    logic                       armed;
    logic                       any_dma;
    logic                       underflow;
    logic [15:0]                ramp_cnt;
    logic                       sample_valid;
    logic [DAC_DATA_WIDTH-1:0]  sample_next;
    logic [DAC_DATA_WIDTH-1:0]  sample_q;
    logic [LINK_DATA_WIDTH-1:0] frame_next;

    // ------------------------------------------------------------------
    // External-sync arm state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            if (EXT_SYNC != 0) begin
                state <= IDLE;
            end else begin
                state <= RUNNING;
            end
        end else begin
            state <= state_next;
        end
    end

    // Disarm has priority over both arm and sync.
    always_comb begin
        state_next = state;
        if (EXT_SYNC == 0) begin
            state_next = RUNNING;
        end else begin
            case (state)
                IDLE, RUNNING: begin
                    if (dac_ext_sync_arm && !dac_ext_sync_disarm) begin
                        state_next = ARMED;
                    end
                end
                ARMED: begin
                    if (dac_ext_sync_disarm) begin
                        state_next = IDLE;
                    end else if (dac_sync_in || dac_sync_manual_req) begin
                        state_next = RUNNING;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign armed           = (state == ARMED);
    assign dac_sync_status = armed;

    // ------------------------------------------------------------------
    // DMA handshake and underflow detection
    // ------------------------------------------------------------------
    assign bus.dac_ready = bus.link_ready & ~armed & ~reset;

    always_comb begin
        any_dma = 1'b0;
        for (int unsigned m = 0; m < NUM_CHANNELS; m++) begin
            if (dac_src_sel[2*m +: 2] == 2'd0) begin
                any_dma = 1'b1;
            end
        end
    end

    assign underflow = bus.dac_ready & ~bus.dac_valid & any_dma;

    // ------------------------------------------------------------------
    // Stage 1: per-channel source select
    // ------------------------------------------------------------------
    // A DMA channel without valid data is left at zero for the beat.
    always_comb begin
        sample_next = '0;
        for (int unsigned m = 0; m < NUM_CHANNELS; m++) begin
            for (int unsigned k = 0; k < DATA_PATH_WIDTH; k++) begin
                case (dac_src_sel[2*m +: 2])
                    2'd0: begin
                        if (bus.dac_valid) begin
                            sample_next[CH_W*m + 16*k +: 16] = bus.dac_data[CH_W*m + 16*k +: 16];
                        end
                    end
                    2'd1:    sample_next[CH_W*m + 16*k +: 16] = dac_const[16*m +: 16];
                    2'd2:    sample_next[CH_W*m + 16*k +: 16] = ramp_cnt + 16'(k);
                    default: sample_next[CH_W*m + 16*k +: 16] = '0;
                endcase
            end
        end
        if (armed) begin
            sample_next = '0;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: framer (pure wiring from the sample register)
    // ------------------------------------------------------------------
    // Each lane-beat octet is traced back to its channel/sample/byte; octet 0
    // of a lane beat lands in that lane's most significant byte.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        for (genvar o = 0; o < OCTETS_PER_BEAT; o++) begin : g_octet
            localparam int FRAME   = o / F;
            localparam int FOCT    = l*F + (o % F);
            localparam int CH      = FOCT / (2*SAMPLES_PER_FRAME);
            localparam int SLOT    = (FOCT % (2*SAMPLES_PER_FRAME)) / 2;
            localparam int HI_OFS  = ((FOCT % 2) == 0) ? 8 : 0;
            localparam int SAMPLE  = FRAME*SAMPLES_PER_FRAME + SLOT;
            localparam int SRC_LSB = CH*CH_W + SAMPLE*16 + HI_OFS;
            assign frame_next[l*BEAT_W + (OCTETS_PER_BEAT-1-o)*8 +: 8] = sample_q[SRC_LSB +: 8];
        end
    end

    // ------------------------------------------------------------------
    // Pipeline registers: everything holds while link_ready is low
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_q       <= '0;
            sample_valid   <= 1'b0;
            bus.link_data  <= '0;
            bus.link_valid <= 1'b0;
            ramp_cnt       <= '0;
            dac_dunf       <= 1'b0;
        end else begin
            dac_dunf <= underflow;
            if (bus.link_ready) begin
                sample_q       <= sample_next;
                sample_valid   <= 1'b1;
                bus.link_data  <= frame_next;
                bus.link_valid <= sample_valid;
                if (!armed) begin
                    ramp_cnt <= ramp_cnt + 16'(DATA_PATH_WIDTH);
                end
            end
        end
    end
endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_framer_core.sv
// Self-checking bench for ad_ip_jesd204_tpl_dac_framer_core.
// Configuration: L=2, M=2, S=1, 4 octets per beat, external sync enabled.
// A frame-level reference model tracks the expected outputs every cycle;
// directed literal checks pin the model to hand-derived values.
module tb_ad_ip_jesd204_tpl_dac_framer_core;
    localparam int NL  = 2;
    localparam int NCH = 2;
    localparam int S   = 1;
    localparam int OPB = 4;
    localparam int LW  = NL*OPB*8;
    localparam int DPW = LW/(16*NCH);
    localparam int DW  = DPW*16*NCH;
    localparam int F   = NCH*S*2/NL;
    localparam int FPB = OPB/F;

    typedef enum int {M_IDLE, M_ARMED, M_RUNNING} m_state_t;

    logic clk = 1'b0;
    logic reset;
    logic [2*NCH-1:0]  dac_src_sel;
    logic [16*NCH-1:0] dac_const;
    logic dac_ext_sync_arm, dac_ext_sync_disarm, dac_sync_in, dac_sync_manual_req;
    logic dac_sync_status, dac_dunf;

    ad_ip_jesd204_tpl_dac_framer_core_if #(
        .DAC_DATA_WIDTH (DW),
        .LINK_DATA_WIDTH(LW)
    ) bus ();

    ad_ip_jesd204_tpl_dac_framer_core #(
        .NUM_LANES        (NL),
        .NUM_CHANNELS     (NCH),
        .SAMPLES_PER_FRAME(S),
        .OCTETS_PER_BEAT  (OPB),
        .EXT_SYNC         (1)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .bus                (bus),
        .dac_src_sel        (dac_src_sel),
        .dac_const          (dac_const),
        .dac_ext_sync_arm   (dac_ext_sync_arm),
        .dac_ext_sync_disarm(dac_ext_sync_disarm),
        .dac_sync_in        (dac_sync_in),
        .dac_sync_manual_req(dac_sync_manual_req),
        .dac_sync_status    (dac_sync_status),
        .dac_dunf           (dac_dunf)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    bit          m_init = 1'b0;
    m_state_t    m_state;
    logic [15:0] m_cnt;
    logic [15:0] m_s1 [NCH][DPW];
    logic        m_s1v;
    logic        m_lv;
    logic [LW-1:0] m_ld;
    logic        m_dunf;
    logic        m_armed;
    logic        m_any_dma;

    // Build each frame as an octet list (channel, sample, MSB, LSB), then
    // deal frames to lanes in time order.
    function automatic logic [LW-1:0] frame_of(input logic [15:0] smp [NCH][DPW]);
        logic [7:0] oct [FPB][2*NCH*S];
        logic [LW-1:0] r;
        r = '0;
        for (int f = 0; f < FPB; f++)
            for (int m = 0; m < NCH; m++)
                for (int s = 0; s < S; s++) begin
                    oct[f][(m*S+s)*2]     = smp[m][f*S+s][15:8];
                    oct[f][(m*S+s)*2 + 1] = smp[m][f*S+s][7:0];
                end
        for (int l = 0; l < NL; l++)
            for (int o = 0; o < OPB; o++)
                r[(l*OPB + (OPB-1-o))*8 +: 8] = oct[o/F][l*F + o%F];
        return r;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_init  = 1'b1;
            m_state = M_IDLE;
            m_cnt   = 16'h0;
            m_s1v   = 1'b0;
            m_lv    = 1'b0;
            m_ld    = '0;
            m_dunf  = 1'b0;
            for (int m = 0; m < NCH; m++)
                for (int k = 0; k < DPW; k++)
                    m_s1[m][k] = 16'h0;
        end else if (m_init) begin
            m_armed   = (m_state == M_ARMED);
            m_any_dma = 1'b0;
            for (int m = 0; m < NCH; m++)
                if (dac_src_sel[2*m +: 2] == 2'd0) m_any_dma = 1'b1;
            m_dunf = bus.link_ready && !m_armed && !bus.dac_valid && m_any_dma;
            if (bus.link_ready) begin
                m_ld  = frame_of(m_s1);
                m_lv  = m_s1v;
                m_s1v = 1'b1;
                for (int m = 0; m < NCH; m++)
                    for (int k = 0; k < DPW; k++) begin
                        if (m_armed) m_s1[m][k] = 16'h0;
                        else case (dac_src_sel[2*m +: 2])
                            2'd0: m_s1[m][k] = bus.dac_valid ? bus.dac_data[(m*DPW+k)*16 +: 16] : 16'h0;
                            2'd1: m_s1[m][k] = dac_const[m*16 +: 16];
                            2'd2: m_s1[m][k] = m_cnt + 16'(k);
                            default: m_s1[m][k] = 16'h0;
                        endcase
                    end
                if (!m_armed) m_cnt = m_cnt + 16'(DPW);
            end
            if (m_state == M_ARMED) begin
                if (dac_ext_sync_disarm) m_state = M_IDLE;
                else if (dac_sync_in || dac_sync_manual_req) m_state = M_RUNNING;
            end else if (dac_ext_sync_arm && !dac_ext_sync_disarm) begin
                m_state = M_ARMED;
            end
        end
    end

    // Compare process
    always @(negedge clk) begin
        if (m_init) begin
            check("link_data", bus.link_data, m_ld);
            check("link_valid", LW'(bus.link_valid), LW'(m_lv));
            check("dac_dunf", LW'(dac_dunf), LW'(m_dunf));
            check("sync_status", LW'(dac_sync_status), LW'(m_state == M_ARMED));
            check("dac_ready", LW'(bus.dac_ready),
                  LW'(bus.link_ready && m_state != M_ARMED && !reset));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_link_data", bus.link_data, '0);
        check("rst_link_valid", LW'(bus.link_valid), '0);
        check("rst_dac_ready", LW'(bus.dac_ready), '0);
        check("rst_sync_status", LW'(dac_sync_status), '0);
        check("rst_dunf", LW'(dac_dunf), '0);
    endtask

    initial begin
        reset               = 1'b1;
        bus.link_ready      = 1'b1;
        bus.dac_valid       = 1'b0;
        bus.dac_data        = '0;
        dac_src_sel         = '0;
        dac_const           = '0;
        dac_ext_sync_arm    = 1'b0;
        dac_ext_sync_disarm = 1'b0;
        dac_sync_in         = 1'b0;
        dac_sync_manual_req = 1'b0;
        repeat (3) step();
        check_reset_outputs();

        // DMA pass-through: 2-cycle latency and octet order
        reset         = 1'b0;
        bus.dac_valid = 1'b1;
        bus.dac_data  = 64'h4444_3333_2222_1111;
        step();
        check("lat1_link_valid", LW'(bus.link_valid), '0);
        step();
        check("dma_link_data", bus.link_data, 64'h3333_4444_1111_2222);
        check("dma_link_valid", LW'(bus.link_valid), LW'(1));

        // Underflow on ch0 while ch1 sends a constant
        dac_src_sel   = 4'b01_00;
        dac_const     = 32'h5A5A_5A5A;
        bus.dac_valid = 1'b0;
        step();
        check("unf_dunf_pulse", LW'(dac_dunf), LW'(1));
        bus.dac_valid = 1'b1;
        step();
        check("unf_dunf_end", LW'(dac_dunf), '0);
        check("unf_link_data", bus.link_data, 64'h5A5A_5A5A_0000_0000);

        // Arm, zero samples, sync, data resumes
        dac_src_sel      = 4'b01_01;
        dac_ext_sync_arm = 1'b1;
        step();
        dac_ext_sync_arm = 1'b0;
        check("arm_status", LW'(dac_sync_status), LW'(1));
        check("arm_ready", LW'(bus.dac_ready), '0);
        repeat (2) step();
        check("arm_zero_data", bus.link_data, '0);
        check("arm_link_valid", LW'(bus.link_valid), LW'(1));
        dac_sync_in = 1'b1;
        step();
        dac_sync_in = 1'b0;
        check("sync_status_low", LW'(dac_sync_status), '0);
        check("sync_ready", LW'(bus.dac_ready), LW'(1));
        repeat (2) step();
        check("sync_data", bus.link_data, 64'h5A5A_5A5A_5A5A_5A5A);
        dac_ext_sync_arm = 1'b1;
        step();
        check("rearm_status", LW'(dac_sync_status), LW'(1));
        dac_ext_sync_disarm = 1'b1;
        step();
        dac_ext_sync_arm    = 1'b0;
        dac_ext_sync_disarm = 1'b0;
        check("disarm_wins", LW'(dac_sync_status), '0);
        check("disarm_ready", LW'(bus.dac_ready), LW'(1));

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset               = ($urandom_range(0, 299) == 0);
            bus.link_ready      = ($urandom_range(0, 9) < 8);
            bus.dac_valid       = ($urandom_range(0, 9) < 8);
            bus.dac_data        = {$urandom, $urandom};
            if ($urandom_range(0, 19) == 0) dac_src_sel = 4'($urandom);
            if ($urandom_range(0, 49) == 0) dac_const = 32'($urandom);
            dac_ext_sync_arm    = ($urandom_range(0, 29) == 0);
            dac_ext_sync_disarm = ($urandom_range(0, 39) == 0);
            dac_sync_in         = ($urandom_range(0, 19) == 0);
            dac_sync_manual_req = ($urandom_range(0, 29) == 0);
            step();
        end

        // Ramp stream, reset mid-stream, restart and 16-bit wrap
        reset               = 1'b0;
        bus.link_ready      = 1'b1;
        bus.dac_valid       = 1'b1;
        dac_src_sel         = 4'b10_10;
        dac_ext_sync_arm    = 1'b0;
        dac_ext_sync_disarm = 1'b0;
        dac_sync_in         = 1'b0;
        dac_sync_manual_req = 1'b0;
        repeat (5) step();
        reset = 1'b1;
        step();
        check_reset_outputs();
        reset = 1'b0;
        step();
        check("ramp_valid_lat", LW'(bus.link_valid), '0);
        step();
        check("ramp_first", bus.link_data, 64'h0000_0001_0000_0001);
        check("ramp_valid", LW'(bus.link_valid), LW'(1));
        step();
        check("ramp_second", bus.link_data, 64'h0002_0003_0002_0003);
        repeat (32766) step();
        check("ramp_top", bus.link_data, 64'hFFFE_FFFF_FFFE_FFFF);
        step();
        check("ramp_wrap", bus.link_data, 64'h0000_0001_0000_0001);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ad_ip_jesd204_tpl_dac_framer_core.md
Name: ad_ip_jesd204_tpl_dac_framer_core

Overview:
Transmit-side transport-layer core for the JESD204 DAC path.
- Takes per-channel sample words from the DMA/DDS side and selects a per-channel data source.
- Gates the stream with the external-sync arm state machine.
- Maps samples into JESD204 lane octets for the link-layer transmitter.
- Sits between the DAC DMA interface and the jesd204_tx link layer.

Parameters:
NUM_LANES, 1, number of JESD204 lanes (L)
NUM_CHANNELS, 1, number of converters (M)
SAMPLES_PER_FRAME, 1, samples per converter per frame (S)
OCTETS_PER_BEAT, 4, octets per lane per clk
EXT_SYNC, 0, 1 enables the arm/sync state machine; 0 ties state to RUNNING
LINK_DATA_WIDTH, NUM_LANES*OCTETS_PER_BEAT*8, link bus width
DATA_PATH_WIDTH, LINK_DATA_WIDTH/(16*NUM_CHANNELS), samples per channel per beat (16 bits per sample, fixed)
DAC_DATA_WIDTH, DATA_PATH_WIDTH*16*NUM_CHANNELS, DMA bus width

Ports:
clk  input  1  core clock (link clock)
reset  input  1  synchronous, active-high reset
dac_valid  input  1  DMA data valid
dac_ready  output  1  DMA data accepted this cycle when dac_valid&dac_ready
dac_data  input  DAC_DATA_WIDTH  channel m occupies [16*DATA_PATH_WIDTH*m +: 16*DATA_PATH_WIDTH], sample 0 in LSBs
dac_src_sel  input  2*NUM_CHANNELS  per-channel source: 0 DMA, 1 constant, 2 ramp, 3 zero
dac_const  input  16*NUM_CHANNELS  per-channel constant sample
dac_ext_sync_arm  input  1  arm request pulse
dac_ext_sync_disarm  input  1  disarm request pulse
dac_sync_in  input  1  external sync (level)
dac_sync_manual_req  input  1  software sync (level)
dac_sync_status  output  1  high while ARMED
dac_dunf  output  1  one-cycle pulse: DMA underflow on a consumed beat
link_valid  output  1  link data valid
link_ready  input  1  link layer consumes link_data when high
link_data  output  LINK_DATA_WIDTH  framed lane data, lane l at [l*OCTETS_PER_BEAT*8 +: OCTETS_PER_BEAT*8]

Behaviour:
Reset values:
- dac_ready=0, dac_sync_status=0, dac_dunf=0, link_valid=0, link_data=0.
- Ramp counters=0.
- Sync state=IDLE if EXT_SYNC=1, else RUNNING.

Pipeline:
- Stage 1: source select into a sample register.
- Stage 2: framer into the link_data register.
- Latency is 2 clk from an accepted dac_data beat to link_data.
- Both stages advance only when link_ready=1; when link_ready=0 every register holds.
- link_valid goes to 1 on the 2nd cycle after reset deasserts with link_ready=1 (pipeline filled), then stays 1 until reset.

DMA handshake:
- dac_ready = link_ready & (state != ARMED) & ~reset.
- Underflow: a beat where dac_ready=1 and dac_valid=0, and at least one channel has source 0. That channel's samples become 0 for the beat, and dac_dunf pulses one cycle.

Sources:
- 1 (constant): dac_const[16m+:16] is repeated in every sample.
- 2 (ramp): sample k of a beat = cnt+k. cnt advances by DATA_PATH_WIDTH per advancing beat, modulo 2^16 (0xFFFF wraps to 0x0000).
- 3 (zero): all-zero samples.
- Changing a channel's source to ramp does not reset cnt.

Sync FSM (EXT_SYNC=1):
- IDLE to ARMED on arm.
- RUNNING to ARMED on arm.
- ARMED to IDLE on disarm.
- ARMED to RUNNING on (dac_sync_in | dac_sync_manual_req)=1 in a cycle with no disarm.
- Arm and disarm in the same cycle: disarm wins (ARMED to IDLE; IDLE/RUNNING unchanged).
- While ARMED:
  - stage 1 loads zeros;
  - ramp counters hold;
  - dac_dunf=0;
  - link_valid is unaffected.
- With EXT_SYNC=0, arm/disarm/sync inputs are ignored and dac_sync_status=0.

Framer:
- Frame size F = M*S*2/L octets per lane.
- Frame octet stream: for channel m=0..M-1, for sample s=0..S-1, sample MSB octet then LSB octet.
- Lane l carries frame octets l*F .. l*F+F-1.
- Within a lane beat, earlier octets sit in higher-order bytes: octet 0 at the MSB byte, matching the deframer's convention.
- Consecutive frames in a beat are time-ordered, earlier frame first.
- Channel m sample index j maps to frame j/S, slot j%S.
- Reset mid-operation clears all registers and the FSM in the same cycle.

Test Plan:
- L=1, M=1, S=1, OCTETS_PER_BEAT=4. Hold link_ready=1 and feed dac_data=0x2222_1111 with dac_valid=1 -> link_data=0x1111_2222 two cycles later, link_valid=1, dac_dunf=0.
- L=2, M=2, S=1, source 2 on both channels -> each beat, lane0 carries ch0 samples (n, n+1) and lane1 carries ch1 samples (n, n+1), with n stepping by 2 per beat. After cnt=0xFFFE the next pair is 0x0000, 0x0001.
- Source 0 with dac_valid=0 for one ready beat -> dac_dunf one-cycle pulse and zero samples for that beat. Source 1 channel in the same beat still shows dac_const=0x5A5A.
- Toggle link_ready low for 3 cycles mid-stream -> link_data and ramp counters frozen and dac_ready=0. Stream resumes with no dropped or duplicated samples.
- EXT_SYNC=1: arm -> dac_sync_status=1, dac_ready=0, zero samples. Then pulse dac_sync_in -> RUNNING next cycle and data follows 2 cycles later. Repeat with arm and disarm in the same cycle from ARMED -> IDLE.
- Assert reset during the ramp stream with link_ready=1 -> the next cycle has all outputs at reset values. Ramp restarts at 0x0000 and link_valid returns after 2 cycles.
